i2c_seq_ctrl: RTL and testbench

Parametrised I2C write sequencer between the register-write FIFO / trigger-mode RAM table and the wishbone I2C master core, running on the pixel clock. It frames each entry as slave-address + ADDR_BYTES address bytes + DATA_BYTES data bytes and pushes it byte-by-byte through the master's transmit/command registers. It adds NACK detection with bounded retry, error reporting and a per-byte watchdog.

---
 rtl/i2c_seq_pkg.sv | 24 ++
 rtl/i2c_wb_byte_wr.sv | 55 +++++
 rtl/i2c_seq_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_i2c_seq_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared constants for the I2C write sequencer: FSM state codes, wishbone
// register addresses of the I2C master and its command bytes.
package i2c_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RD_RAM  = 3'd1;
    localparam state_t ST_RD_FIFO = 3'd2;
    localparam state_t ST_LATCH   = 3'd3;
    localparam state_t ST_SEND    = 3'd4;
    localparam state_t ST_ABORT   = 3'd5;

    localparam logic [2:0] WB_ADR_TXR  = 3'd3;
    localparam logic [2:0] WB_ADR_CR   = 3'd4;
    localparam logic [2:0] WB_ADR_IDLE = 3'd7;
    localparam logic [7:0] WB_DAT_IDLE = 8'hAF;

    localparam logic [7:0] CMD_START_WR = 8'h90;
    localparam logic [7:0] CMD_WR       = 8'h10;
    localparam logic [7:0] CMD_WR_STOP  = 8'h50;
    localparam logic [7:0] CMD_STOP     = 8'h40;

endpackage

// File: rtl/i2c_wb_byte_wr.sv
// Per-byte micro-sequencer: walks a 0..7 counter and drives the TXR write
// followed by the CR write onto the I2C master's wishbone port.
module i2c_wb_byte_wr
    import i2c_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_active,
    input  logic       i_clr,
    input  logic       i_txr_en,
    input  logic [7:0] i_txr,
    input  logic [7:0] i_cr,
    output logic [2:0] ov_wb_adr,
    output logic [7:0] ov_wb_dat,
    output logic       o_wb_we
);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!i_active || i_clr) begin
            cnt_d = 3'd0;
        end else if (cnt_q != 3'd7) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Each register write is held for two cycles so the master sees a clean strobe.
    always_comb begin
        ov_wb_adr = WB_ADR_IDLE;
        ov_wb_dat = WB_DAT_IDLE;
        o_wb_we   = 1'b0;
        if (i_active) begin
            if (i_txr_en && (cnt_q == 3'd1 || cnt_q == 3'd2)) begin
                ov_wb_adr = WB_ADR_TXR;
                ov_wb_dat = i_txr;
                o_wb_we   = 1'b1;
            end else if (cnt_q == 3'd5 || cnt_q == 3'd6) begin
                ov_wb_adr = WB_ADR_CR;
                ov_wb_dat = i_cr;
                o_wb_we   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_seq_ctrl.sv
// I2C write sequencer: frames FIFO or trigger-table entries into slave-address,
// address and data bytes, with NACK retry, drop reporting and a byte watchdog.
//
// state    | meaning
// IDLE     | waiting for trigger or FIFO data
// RD_RAM   | table address presented, read in flight
// RD_FIFO  | FIFO read pulsed, read in flight
// LATCH    | capture entry, apply restart-register override
// SEND     | pushing byte k through TXR/CR
// ABORT    | slave NACKed, issuing STOP
module i2c_seq_ctrl
    import i2c_seq_pkg::*;
#(
    parameter logic [6:0]                  SLAVE_ADDR = 7'h37,
    parameter int                          ADDR_BYTES = 2,
    parameter int                          DATA_BYTES = 2,
    parameter int                          RAM_DEPTH  = 19,
    parameter int                          FIXED_IDX  = 17,
    parameter logic [8*DATA_BYTES-1:0]     FIXED_DATA = 16'h8006,
    parameter int                          MAX_RETRY  = 2,
    parameter int                          WD_W       = 16
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   i_trigger,
    input  logic                                   i_trigger_mode_fall,
    input  logic                                   i_fifo_rdy,
    output logic                                   o_fifo_rden,
    input  logic [8*(ADDR_BYTES+DATA_BYTES)-1:0]   iv_fifo_q,
    output logic [$clog2(RAM_DEPTH)-1:0]           ov_ram_addr,
    input  logic [8*(ADDR_BYTES+DATA_BYTES)-1:0]   iv_ram_q,
    output logic [2:0]                             ov_wb_adr,
    output logic [7:0]                             ov_wb_dat,
    output logic                                   o_wb_we,
    output logic                                   o_wb_stb,
    output logic                                   o_wb_cyc,
    input  logic                                   i_done,
    input  logic                                   i_rxack,
    output logic                                   o_state_idle,
    output logic                                   o_trigger_start,
    output logic                                   o_nack_err,
    output logic [7:0]                             ov_nack_cnt
);

    localparam int EW     = 8*(ADDR_BYTES+DATA_BYTES);
    localparam int NB     = 1+ADDR_BYTES+DATA_BYTES;
    localparam int RAM_AW = $clog2(RAM_DEPTH);

    localparam logic [RAM_AW-1:0] LAST_A      = RAM_AW'(RAM_DEPTH-1);
    localparam logic [RAM_AW-1:0] FIXED_A     = RAM_AW'(FIXED_IDX);
    localparam logic [RAM_AW-1:0] TRIG_CLR_A  = RAM_AW'(FIXED_IDX-1);
    localparam logic [3:0]        K_LAST      = 4'(NB-1);
    localparam logic [7:0]        MAX_R       = 8'(MAX_RETRY);

    state_t            state_q, state_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic              mode_q, mode_d;
    logic [EW-1:0]     entry_q, entry_d;
    logic [3:0]        k_q, k_d;
    logic [7:0]        retry_q, retry_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [7:0]        nack_cnt_q, nack_cnt_d;
    logic              nack_err_q, nack_err_d;
    logic              fifo_rden_q, fifo_rden_d;
    logic              trig_start_q, trig_start_d;

    logic [EW-1:0]     ram_entry;
    logic              entry_done;
    logic [7:0]        txr;
    logic [7:0]        cr;

    always_comb begin
        ram_entry = iv_ram_q;
        if (addr_q == FIXED_A) begin
            ram_entry[8*DATA_BYTES-1:0] = FIXED_DATA;
        end
    end

    always_comb begin
        txr = {SLAVE_ADDR, 1'b0};
        for (int i = 1; i < NB; i++) begin
            if (k_q == 4'(i)) begin
                txr = entry_q[EW-8*i +: 8];
            end
        end
        if (state_q == ST_ABORT) begin
            cr = CMD_STOP;
        end else if (k_q == 4'd0) begin
            cr = CMD_START_WR;
        end else if (k_q == K_LAST) begin
            cr = CMD_WR_STOP;
        end else begin
            cr = CMD_WR;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mode_d      = mode_q;
        entry_d     = entry_q;
        k_d         = k_q;
        retry_d     = retry_q;
        nack_cnt_d  = nack_cnt_q;
        nack_err_d  = 1'b0;
        fifo_rden_d = 1'b0;
        entry_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_trigger || i_trigger_mode_fall) begin
                    state_d = ST_RD_RAM;
                    addr_d  = '0;
                    mode_d  = 1'b1;
                end else if (i_fifo_rdy) begin
                    state_d     = ST_RD_FIFO;
                    mode_d      = 1'b0;
                    fifo_rden_d = 1'b1;
                end
            end
            ST_RD_RAM, ST_RD_FIFO: state_d = ST_LATCH;
            ST_LATCH: begin
                entry_d = mode_q ? ram_entry : iv_fifo_q;
                k_d     = 4'd0;
                retry_d = 8'd0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (i_done) begin
                    if (i_rxack) begin
                        state_d = ST_ABORT;
                    end else if (k_q == K_LAST) begin
                        entry_done = 1'b1;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end
            end
            ST_ABORT: begin
                if (i_done) begin
                    if (retry_q < MAX_R) begin
                        retry_d = retry_q + 8'd1;
                        k_d     = 4'd0;
                        state_d = ST_SEND;
                    end else begin
                        nack_err_d = 1'b1;
                        if (nack_cnt_q != 8'hFF) begin
                            nack_cnt_d = nack_cnt_q + 8'd1;
                        end
                        entry_done = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (entry_done) begin
            retry_d = 8'd0;
            if (mode_q && addr_q != LAST_A) begin
                addr_d  = addr_q + RAM_AW'(1);
                state_d = ST_RD_RAM;
            end else begin
                addr_d  = '0;
                state_d = ST_IDLE;
            end
        end

        wd_d = wd_q + WD_W'(1);
        if (state_q == ST_IDLE || i_done || state_d != state_q) begin
            wd_d = '0;
        end
        // A stuck master abandons the frame silently; the next request restarts cleanly.
        if (wd_q[WD_W-1]) begin
            state_d = ST_IDLE;
            retry_d = 8'd0;
            wd_d    = '0;
        end

        trig_start_d = trig_start_q;
        if (i_trigger) begin
            trig_start_d = 1'b1;
        end else if (addr_q == TRIG_CLR_A) begin
            trig_start_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            mode_q       <= 1'b0;
            entry_q      <= '0;
            k_q          <= 4'd0;
            retry_q      <= 8'd0;
            wd_q         <= '0;
            nack_cnt_q   <= 8'd0;
            nack_err_q   <= 1'b0;
            fifo_rden_q  <= 1'b0;
            trig_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            mode_q       <= mode_d;
            entry_q      <= entry_d;
            k_q          <= k_d;
            retry_q      <= retry_d;
            wd_q         <= wd_d;
            nack_cnt_q   <= nack_cnt_d;
            nack_err_q   <= nack_err_d;
            fifo_rden_q  <= fifo_rden_d;
            trig_start_q <= trig_start_d;
        end
    end

    i2c_wb_byte_wr u_byte_wr (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_active  (state_q == ST_SEND || state_q == ST_ABORT),
        .i_clr     (i_done),
        .i_txr_en  (state_q == ST_SEND),
        .i_txr     (txr),
        .i_cr      (cr),
        .ov_wb_adr (ov_wb_adr),
        .ov_wb_dat (ov_wb_dat),
        .o_wb_we   (o_wb_we)
    );

    assign o_wb_stb        = 1'b1;
    assign o_wb_cyc        = 1'b1;
    assign o_fifo_rden     = fifo_rden_q;
    assign ov_ram_addr     = addr_q;
    assign o_state_idle    = (state_q == ST_IDLE);
    assign o_trigger_start = trig_start_q;
    assign o_nack_err      = nack_err_q;
    assign ov_nack_cnt     = nack_cnt_q;

endmodule

// File: tb/tb_i2c_seq_ctrl.sv
// Bench for i2c_seq_ctrl: a responding I2C master model, a table RAM model and
// a frame-level reference that lists the expected wishbone writes per entry.
module tb_i2c_seq_ctrl;

    localparam int          AB         = 2;
    localparam int          DB         = 2;
    localparam int          EW         = 8*(AB+DB);
    localparam int          NB         = 1+AB+DB;
    localparam int          RAM_DEPTH  = 19;
    localparam int          FIXED_IDX  = 17;
    localparam int          MAX_RETRY  = 2;
    localparam int          WD_W       = 16;
    localparam logic [6:0]  SLAVE_ADDR = 7'h37;
    localparam logic [15:0] FIXED_DATA = 16'h8006;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_trigger = 1'b0;
    logic          i_trigger_mode_fall = 1'b0;
    logic          i_fifo_rdy = 1'b0;
    logic          i_done = 1'b0;
    logic          i_rxack = 1'b0;
    logic [EW-1:0] iv_fifo_q = '0;
    logic [EW-1:0] iv_ram_q = '0;

    logic          o_fifo_rden, o_wb_we, o_wb_stb, o_wb_cyc;
    logic          o_state_idle, o_trigger_start, o_nack_err;
    logic [4:0]    ov_ram_addr;
    logic [2:0]    ov_wb_adr;
    logic [7:0]    ov_wb_dat, ov_nack_cnt;

    i2c_seq_ctrl #(
        .SLAVE_ADDR(SLAVE_ADDR), .ADDR_BYTES(AB), .DATA_BYTES(DB),
        .RAM_DEPTH(RAM_DEPTH), .FIXED_IDX(FIXED_IDX), .FIXED_DATA(FIXED_DATA),
        .MAX_RETRY(MAX_RETRY), .WD_W(WD_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_trigger(i_trigger), .i_trigger_mode_fall(i_trigger_mode_fall),
        .i_fifo_rdy(i_fifo_rdy), .o_fifo_rden(o_fifo_rden), .iv_fifo_q(iv_fifo_q),
        .ov_ram_addr(ov_ram_addr), .iv_ram_q(iv_ram_q),
        .ov_wb_adr(ov_wb_adr), .ov_wb_dat(ov_wb_dat), .o_wb_we(o_wb_we),
        .o_wb_stb(o_wb_stb), .o_wb_cyc(o_wb_cyc),
        .i_done(i_done), .i_rxack(i_rxack),
        .o_state_idle(o_state_idle), .o_trigger_start(o_trigger_start),
        .o_nack_err(o_nack_err), .ov_nack_cnt(ov_nack_cnt)
    );

    always #5 clk = ~clk;

    logic [EW-1:0] ram [32];
    always @(posedge clk) iv_ram_q <= ram[ov_ram_addr];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Responder / monitor state; only the always block below writes these.
    logic [10:0] got_q [$];
    int          rden_cnt = 0, nerr_cnt = 0, trig_fall_cnt = 0, trig_fall_addr = -1;
    int          cur_byte = 0, attempt = 0, done_dly = 0;
    logic        prev_we = 1'b0, prev_trig = 1'b0;
    logic [2:0]  prev_adr = 3'd0;
    logic [7:0]  last_cr = 8'h00;

    // Responder policy; only the initial block writes these.
    int          nack_byte = -1;
    int          nack_att = 0;
    bit          resp_en = 1'b1;

    always @(negedge clk) begin
        if (!reset_n) begin
            done_dly  = 0;
            i_done    = 1'b0;
            i_rxack   = 1'b0;
            prev_we   = 1'b0;
            prev_trig = 1'b0;
        end else begin
            if (i_done) begin
                i_done  = 1'b0;
                i_rxack = 1'b0;
            end
            if (o_state_idle) attempt = 0;
            if (o_fifo_rden) rden_cnt++;
            if (o_nack_err) nerr_cnt++;
            if (prev_trig && !o_trigger_start) begin
                trig_fall_cnt++;
                trig_fall_addr = 32'(ov_ram_addr);
            end
            prev_trig = o_trigger_start;
            if (o_wb_we && !(prev_we && prev_adr == ov_wb_adr)) begin
                got_q.push_back({ov_wb_adr, ov_wb_dat});
                if (ov_wb_adr == 3'd4) begin
                    last_cr = ov_wb_dat;
                    if (ov_wb_dat == 8'h90) cur_byte = 0;
                    else if (ov_wb_dat != 8'h40) cur_byte++;
                    done_dly = 2 + int'($urandom_range(0, 3));
                end
            end else if (done_dly > 0) begin
                done_dly--;
                if (done_dly == 0 && resp_en) begin
                    i_done  = 1'b1;
                    i_rxack = (last_cr != 8'h40) && (cur_byte == nack_byte) && (attempt < nack_att);
                    if (last_cr == 8'h40) attempt++;
                end
            end
            prev_we  = o_wb_we;
            prev_adr = ov_wb_adr;
        end
    end

    // Reference: expected wishbone writes of one entry given the NACK policy.
    logic [10:0] exp_q [$];
    int          exp_nack = 0;

    task automatic model_frame(input logic [EW-1:0] e, input int nb, input int na);
        bit         fin;
        bit         nacked;
        logic [7:0] tx;
        logic [7:0] c;
        fin = 1'b0;
        for (int at = 0; at <= MAX_RETRY; at++) begin
            if (!fin) begin
                nacked = 1'b0;
                for (int b = 0; b < NB; b++) begin
                    if (!nacked) begin
                        tx = (b == 0) ? {SLAVE_ADDR, 1'b0} : e[EW-8*b +: 8];
                        c  = (b == 0) ? 8'h90 : (b == NB-1) ? 8'h50 : 8'h10;
                        exp_q.push_back({3'd3, tx});
                        exp_q.push_back({3'd4, c});
                        if (b == nb && at < na) begin
                            exp_q.push_back({3'd4, 8'h40});
                            nacked = 1'b1;
                        end
                    end
                end
                if (!nacked) fin = 1'b1;
            end
        end
        if (!fin) exp_nack = (exp_nack < 255) ? exp_nack + 1 : 255;
    endtask

    task automatic cmp_frames(input string tag, input int base);
        chk({tag, "_nwr"}, 32'(got_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size()) chk(tag, 32'(got_q[base+i]), 32'(exp_q[i]));
        end
        exp_q.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (!o_state_idle && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 32'(o_state_idle), 32'd1);
    endtask

    task automatic start_fifo(input logic [EW-1:0] e);
        @(negedge clk);
        iv_fifo_q  = e;
        i_fifo_rdy = 1'b1;
        @(posedge clk);
        #1 i_fifo_rdy = 1'b0;
    endtask

    task automatic fifo_frame(input string tag, input logic [EW-1:0] e, input int nb, input int na);
        int base, e0, n0;
        nack_byte = nb;
        nack_att  = na;
        base = got_q.size();
        e0   = exp_nack;
        n0   = nerr_cnt;
        model_frame(e, nb, na);
        start_fifo(e);
        wait_idle(tag, 3000);
        @(negedge clk);
        cmp_frames(tag, base);
        chk({tag, "_nack_cnt"}, 32'(ov_nack_cnt), 32'(exp_nack));
        chk({tag, "_nack_pulses"}, 32'(nerr_cnt - n0), 32'(exp_nack - e0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_adr"},   32'(ov_wb_adr), 32'd7);
        chk({tag, "_dat"},   32'(ov_wb_dat), 32'hAF);
        chk({tag, "_we"},    32'(o_wb_we), 32'd0);
        chk({tag, "_stb"},   32'(o_wb_stb), 32'd1);
        chk({tag, "_cyc"},   32'(o_wb_cyc), 32'd1);
        chk({tag, "_idle"},  32'(o_state_idle), 32'd1);
        chk({tag, "_rden"},  32'(o_fifo_rden), 32'd0);
        chk({tag, "_raddr"}, 32'(ov_ram_addr), 32'd0);
        chk({tag, "_tstart"},32'(o_trigger_start), 32'd0);
        chk({tag, "_nerr"},  32'(o_nack_err), 32'd0);
        chk({tag, "_ncnt"},  32'(ov_nack_cnt), 32'd0);
    endtask

    int            base, lat, n, r0, tf0, n0, e0, nb;
    logic [EW-1:0] e;

    initial begin
        for (int a = 0; a < 32; a++) ram[a] = $urandom;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Directed FIFO frame, including IDLE-to-first-TXR latency.
        nack_byte = -1;
        nack_att  = 0;
        base = got_q.size();
        r0   = rden_cnt;
        model_frame(32'h3012_0A55, -1, 0);
        @(negedge clk);
        iv_fifo_q  = 32'h3012_0A55;
        i_fifo_rdy = 1'b1;
        @(posedge clk);
        #1 i_fifo_rdy = 1'b0;
        chk("fifo_rden_pulse", 32'(o_fifo_rden), 32'd1);
        lat = 0;
        while (lat < 10 && !(o_wb_we && ov_wb_adr == 3'd3)) begin
            @(negedge clk);
            lat++;
        end
        chk("first_txr_latency", 32'(lat), 32'd4);
        chk("first_txr_data", 32'(ov_wb_dat), 32'h6E);
        wait_idle("fifo_dir", 1000);
        @(negedge clk);
        cmp_frames("fifo_dir", base);
        chk("fifo_dir_rden_cnt", 32'(rden_cnt - r0), 32'd1);

        // NACK on byte 2 on every attempt: three attempts, then drop.
        fifo_frame("nack_dir", $urandom, 2, 1000);
        chk("nack_dir_cnt1", 32'(ov_nack_cnt), 32'd1);

        for (int i = 0; i < 8; i++) begin
            nb = int'($urandom_range(0, NB)) - 1;
            fifo_frame("fifo_rand", $urandom, nb, int'($urandom_range(1, 3)));
        end

        // Trigger and FIFO ready together: trigger sweep wins, FIFO untouched.
        nack_byte = -1;
        nack_att  = 0;
        base = got_q.size();
        r0   = rden_cnt;
        tf0  = trig_fall_cnt;
        for (int a = 0; a < RAM_DEPTH; a++) begin
            e = ram[a];
            if (a == FIXED_IDX) e[15:0] = FIXED_DATA;
            model_frame(e, -1, 0);
        end
        @(negedge clk);
        i_trigger  = 1'b1;
        i_fifo_rdy = 1'b1;
        iv_fifo_q  = $urandom;
        @(posedge clk);
        #1 i_trigger = 1'b0;
        i_fifo_rdy = 1'b0;
        chk("sweep_tstart_set", 32'(o_trigger_start), 32'd1);
        chk("sweep_busy", 32'(o_state_idle), 32'd0);
        wait_idle("sweep", 8000);
        @(negedge clk);
        cmp_frames("sweep", base);
        chk("sweep_rden", 32'(rden_cnt - r0), 32'd0);
        chk("sweep_tstart_falls", 32'(trig_fall_cnt - tf0), 32'd1);
        chk("sweep_tstart_fall_addr", 32'(trig_fall_addr), 32'(FIXED_IDX-1));
        chk("sweep_addr_wrap", 32'(ov_ram_addr), 32'd0);

        // Mode-fall sweep with every entry NACKed and dropped.
        nack_byte = int'($urandom_range(0, NB-1));
        nack_att  = 1000;
        base = got_q.size();
        n0   = nerr_cnt;
        e0   = exp_nack;
        for (int a = 0; a < RAM_DEPTH; a++) begin
            e = ram[a];
            if (a == FIXED_IDX) e[15:0] = FIXED_DATA;
            model_frame(e, nack_byte, 1000);
        end
        @(negedge clk);
        i_trigger_mode_fall = 1'b1;
        @(posedge clk);
        #1 i_trigger_mode_fall = 1'b0;
        chk("mfall_no_tstart", 32'(o_trigger_start), 32'd0);
        wait_idle("mfall", 20000);
        @(negedge clk);
        cmp_frames("mfall", base);
        chk("mfall_nack_cnt", 32'(ov_nack_cnt), 32'(exp_nack));
        chk("mfall_nack_pulses", 32'(nerr_cnt - n0), 32'(exp_nack - e0));

        // Watchdog: master never completes the byte.
        nack_byte = -1;
        resp_en   = 1'b0;
        n0 = nerr_cnt;
        start_fifo(32'h1122_3344);
        n = 0;
        while (n < 32000 && !o_state_idle) begin
            @(negedge clk);
            n++;
        end
        chk("wd_not_early", 32'(o_state_idle), 32'd0);
        wait_idle("wd", 1000);
        @(negedge clk);
        chk("wd_no_err_pulse", 32'(nerr_cnt - n0), 32'd0);
        chk("wd_nack_cnt_kept", 32'(ov_nack_cnt), 32'(exp_nack));
        resp_en = 1'b1;
        fifo_frame("after_wd", $urandom, 1, 1);

        // Asynchronous reset in the middle of a byte.
        nack_byte = -1;
        start_fifo($urandom);
        n = 0;
        while (n < 50 && !o_wb_we) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_busy", 32'(o_wb_we), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        reset_n  = 1'b1;
        exp_nack = 0;
        @(negedge clk);
        fifo_frame("after_rst", $urandom, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
